// File: rtl/pulse_stretcher_multi_if.sv
// Trigger/stretch-length inputs and stretched/overrun/busy outputs of the
// multi-channel pulse stretcher, bundled for connection between blocks.
interface pulse_stretcher_multi_if #(
   parameter int par_channels       = 4,
   parameter int par_T_stretch_bits = 7
);
   logic [par_channels-1:0]       i_x;
   logic [par_T_stretch_bits-1:0] i_t_stretch;
   logic [par_channels-1:0]       o_y;
   logic [par_channels-1:0]       o_overrun;
   logic                          o_busy;

   modport master (
      output i_x,
      output i_t_stretch,
      input  o_y,
      input  o_overrun,
      input  o_busy
   );

   modport slave (
      input  i_x,
      input  i_t_stretch,
      output o_y,
      output o_overrun,
      output o_busy
   );
endinterface

// File: rtl/pulse_stretcher_multi.sv
// Multi-channel pulse stretcher: each channel holds its output high for a
// runtime length after a trigger, with optional retrigger, edge mode and hold-off.
module pulse_stretcher_multi #(
   parameter int par_channels       = 4,
   parameter int par_T_stretch_max  = 64,
   parameter int par_T_stretch_bits = $clog2(par_T_stretch_max + 1),
   parameter int par_T_holdoff      = 0,
   parameter int par_retrigger      = 0,
   parameter int par_edge           = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   pulse_stretcher_multi_if.slave   bus
);
   localparam int HO_BITS = (par_T_holdoff > 0) ? $clog2(par_T_holdoff + 1) : 1;
   localparam int CNT_W   = (par_T_stretch_bits > HO_BITS) ? par_T_stretch_bits : HO_BITS;

   localparam logic [par_T_stretch_bits-1:0] MAX_V   = par_T_stretch_bits'(par_T_stretch_max);
   localparam logic [CNT_W-1:0]              HO_LOAD = CNT_W'((par_T_holdoff > 0) ? par_T_holdoff - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_HOLDOFF
   } state_t;

   logic [par_T_stretch_bits-1:0] neff;
   logic [par_channels-1:0]       y_vec;
   logic [par_channels-1:0]       ov_vec;
   logic [par_channels-1:0]       act_vec;

   // One clamped length shared by every channel; each channel samples it on acceptance.
   assign neff = (bus.i_t_stretch > MAX_V) ? MAX_V : bus.i_t_stretch;

   generate
      for (genvar gi = 0; gi < par_channels; gi++) begin : g_ch
         state_t           state_reg;
         logic [CNT_W-1:0] cnt_reg;
         logic             y_reg;
         logic             ov_reg;
         logic             act_reg;
         logic             x_d_reg;
         logic             trig;
         logic             reload;

         assign trig   = (par_edge != 0) ? (bus.i_x[gi] & ~x_d_reg) : bus.i_x[gi];
         assign reload = trig && (neff != '0);

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               state_reg <= ST_IDLE;
               cnt_reg   <= '0;
               y_reg     <= 1'b0;
               ov_reg    <= 1'b0;
               act_reg   <= 1'b0;
               x_d_reg   <= 1'b0;
            end else begin
               x_d_reg <= bus.i_x[gi];
               ov_reg  <= 1'b0;
               case (state_reg)
                  ST_IDLE: begin
                     if (reload) begin
                        state_reg <= ST_HOLD;
                        cnt_reg   <= CNT_W'(neff - 1'b1);
                        y_reg     <= 1'b1;
                        act_reg   <= 1'b1;
                     end
                  end
                  ST_HOLD: begin
                     if ((par_retrigger != 0) && reload) begin
                        cnt_reg <= CNT_W'(neff - 1'b1);
                     end else begin
                        if (trig && (par_retrigger == 0)) begin
                           ov_reg <= 1'b1;
                        end
                        if (cnt_reg == '0) begin
                           y_reg <= 1'b0;
                           if (par_T_holdoff > 0) begin
                              state_reg <= ST_HOLDOFF;
                              cnt_reg   <= HO_LOAD;
                           end else begin
                              state_reg <= ST_IDLE;
                              act_reg   <= 1'b0;
                           end
                        end else begin
                           cnt_reg <= cnt_reg - 1'b1;
                        end
                     end
                  end
                  ST_HOLDOFF: begin
                     if (trig) begin
                        ov_reg <= 1'b1;
                     end
                     if (cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                        act_reg   <= 1'b0;
                     end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                     end
                  end
                  default: begin
                     state_reg <= ST_IDLE;
                     cnt_reg   <= '0;
                     y_reg     <= 1'b0;
                     act_reg   <= 1'b0;
                  end
               endcase
            end
         end

         assign y_vec[gi]   = y_reg;
         assign ov_vec[gi]  = ov_reg;
         assign act_vec[gi] = act_reg;
      end
   endgenerate

   // act_reg mirrors (state != IDLE) in lockstep, so busy aligns with o_y.
   assign bus.o_y       = y_vec;
   assign bus.o_overrun = ov_vec;
   assign bus.o_busy    = |act_vec;
endmodule

// File: tb/tb_pulse_stretcher_multi.sv
// Four stretcher configurations (plain, retrigger, hold-off, edge) share one
// stimulus stream and are checked against a window-based reference model.
module tb_pulse_stretcher_multi;
   localparam int NCH = 4;
   localparam int NCFG = 4;
   localparam int TSB = 7;
   localparam int TMAX = 64;

   logic clk = 1'b0;
   logic rst;
   logic [NCH-1:0] x;
   logic [TSB-1:0] t_stretch;

   logic [NCFG-1:0][NCH-1:0] y_obs;
   logic [NCFG-1:0][NCH-1:0] ov_obs;
   logic [NCFG-1:0]          busy_obs;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
         pulse_stretcher_multi_if #(.par_channels(NCH), .par_T_stretch_bits(TSB)) bus ();
         assign bus.i_x         = x;
         assign bus.i_t_stretch = t_stretch;
         assign y_obs[gi]    = bus.o_y;
         assign ov_obs[gi]   = bus.o_overrun;
         assign busy_obs[gi] = bus.o_busy;
         pulse_stretcher_multi #(
            .par_channels      (NCH),
            .par_T_stretch_max (TMAX),
            .par_T_stretch_bits(TSB),
            .par_T_holdoff     ((gi == 2) ? 3 : 0),
            .par_retrigger     ((gi == 1) ? 1 : 0),
            .par_edge          ((gi == 3) ? 1 : 0)
         ) u_dut (
            .i_clk(clk),
            .i_rst(rst),
            .bus  (bus)
         );
      end
   endgenerate

   // Configuration table for the model.
   int retrig_cfg [NCFG] = '{0, 1, 0, 0};
   int hold_cfg   [NCFG] = '{0, 0, 3, 0};
   int edge_cfg   [NCFG] = '{0, 0, 0, 1};

   // Model: each channel's pulse is a window of edges; high while edge < hi_end,
   // hold-off while hi_end <= edge < ho_end, idle afterwards.
   int hi_end [NCFG][NCH];
   int ho_end [NCFG][NCH];
   logic [NCH-1:0] xprev;
   logic [NCFG-1:0][NCH-1:0] y_exp;
   logic [NCFG-1:0][NCH-1:0] ov_exp;
   logic [NCFG-1:0]          busy_exp;

   int k;
   int n_cmp;
   int n_bad;
   int hi_cnt0;

   task automatic check(input string tag, input int cfg, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s cfg%0d edge %0d: observed %0h expected %0h", tag, cfg, k, obs, exp);
      end
   endtask

   task automatic model_step();
      int neff;
      logic trig;
      neff = (int'(t_stretch) > TMAX) ? TMAX : int'(t_stretch);
      for (int c = 0; c < NCFG; c++) begin
         ov_exp[c]   = '0;
         busy_exp[c] = 1'b0;
         for (int ch = 0; ch < NCH; ch++) begin
            if (rst) begin
               hi_end[c][ch] = 0;
               ho_end[c][ch] = 0;
            end else begin
               trig = (edge_cfg[c] != 0) ? (x[ch] & ~xprev[ch]) : x[ch];
               if (trig) begin
                  if (k < hi_end[c][ch]) begin
                     if (retrig_cfg[c] != 0) begin
                        if (neff > 0) begin
                           hi_end[c][ch] = k + 1 + neff;
                           ho_end[c][ch] = hi_end[c][ch] + hold_cfg[c];
                        end
                     end else begin
                        ov_exp[c][ch] = 1'b1;
                     end
                  end else if (k < ho_end[c][ch]) begin
                     ov_exp[c][ch] = 1'b1;
                  end else if (neff > 0) begin
                     hi_end[c][ch] = k + 1 + neff;
                     ho_end[c][ch] = hi_end[c][ch] + hold_cfg[c];
                  end
               end
            end
            y_exp[c][ch] = (k + 1 < hi_end[c][ch]);
            if (k + 1 < ho_end[c][ch]) busy_exp[c] = 1'b1;
         end
      end
      xprev = rst ? '0 : x;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      for (int c = 0; c < NCFG; c++) begin
         check("o_y", c, 32'(y_obs[c]), 32'(y_exp[c]));
         check("o_overrun", c, 32'(ov_obs[c]), 32'(ov_exp[c]));
         check("o_busy", c, 32'(busy_obs[c]), 32'(busy_exp[c]));
      end
      if (y_obs[0][0] === 1'b1) hi_cnt0++;
      k++;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; k = 0; hi_cnt0 = 0;
      xprev = '0;
      for (int c = 0; c < NCFG; c++)
         for (int ch = 0; ch < NCH; ch++) begin
            hi_end[c][ch] = 0;
            ho_end[c][ch] = 0;
         end
      rst = 1'b1; x = '0; t_stretch = '0;
      @(negedge clk);
      tick(); tick();
      rst = 1'b0;

      // Single 5-cycle pulse on channel 0.
      t_stretch = 7'd5;
      repeat (3) tick();
      hi_cnt0 = 0;
      x = 4'b0001; tick(); x = '0;
      repeat (8) tick();
      check("len5", 0, 32'(hi_cnt0), 32'd5);

      // Second trigger three cycles into an 8-cycle pulse on channel 1.
      t_stretch = 7'd8;
      x = 4'b0010; tick(); x = '0;
      tick(); tick();
      x = 4'b0010; tick(); x = '0;
      repeat (14) tick();

      // Level held on channel 2 with N=4.
      t_stretch = 7'd4;
      x = 4'b0100; repeat (20) tick(); x = '0;
      repeat (10) tick();

      // Level held on channel 3 with N=6; then N=0 and an over-range length.
      t_stretch = 7'd6;
      x = 4'b1000; repeat (30) tick(); x = '0;
      repeat (10) tick();
      t_stretch = 7'd0;
      x = 4'b1000; tick(); x = '0;
      repeat (3) tick();
      t_stretch = 7'd127;
      hi_cnt0 = 0;
      x = 4'b1001; tick(); x = '0;
      repeat (70) tick();
      check("len_clamp", 0, 32'(hi_cnt0), 32'd64);

      // All channels at once, reset on the second output cycle, then retrigger.
      t_stretch = 7'd3;
      x = 4'hF; tick(); x = '0;
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      tick();
      x = 4'b0001; tick(); x = '0;
      repeat (5) tick();

      // Randomized traffic with short lengths and occasional resets.
      repeat (1500) begin
         x = 4'($urandom_range(0, 15)) & (($urandom_range(0, 2) == 0) ? 4'hF : 4'h0);
         case ($urandom_range(0, 9))
            0:       t_stretch = 7'd0;
            1:       t_stretch = 7'($urandom_range(60, 127));
            default: t_stretch = 7'($urandom_range(1, 9));
         endcase
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0; x = '0;
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
